if_id_buffer: RTL



---
 rtl/if_id_buffer.sv | 92 +++++++++
 1 files changed

// File: rtl/if_id_buffer.sv
// IF/ID boundary stage: DEPTH-entry circular buffer of {pc, instr} feeding decode.
// Optional perf counters (stall_cycles, flush_count) are enabled by defining IF_ID_PERF_EN.
module if_id_buffer #(
   parameter int DEPTH    = 2,
   parameter int PC_WIDTH = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fetch_valid,
   output logic                fetch_ready,
   input  logic [PC_WIDTH-1:0] fetch_pc,
   input  logic [31:0]         fetch_instr,
   output logic                id_valid,
   output logic [PC_WIDTH-1:0] id_pc,
   output logic [31:0]         id_instruction,
   input  logic                id_stall,
`ifdef IF_ID_PERF_EN
   output logic [31:0]         stall_cycles,
   output logic [31:0]         flush_count,
`endif
   input  logic                flush
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [PC_WIDTH-1:0] r_pc_mem    [DEPTH];
   logic [31:0]         r_instr_mem [DEPTH];
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [AW:0]         r_count;

   logic w_push;
   logic w_pop;

   // Ready is derived from registered count only, so stall/flush never reach fetch combinationally.
   assign fetch_ready    = (r_count != CNT_FULL) && rst_n;
   assign id_valid       = (r_count != '0);
   assign id_pc          = id_valid ? r_pc_mem[r_rd_ptr]    : '0;
   assign id_instruction = id_valid ? r_instr_mem[r_rd_ptr] : '0;

   assign w_push = fetch_valid && fetch_ready && !flush;
   assign w_pop  = id_valid && !id_stall && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
         else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
      end
   end

   // Payload is not reset; the output mux masks stale entries while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]    <= fetch_pc;
         r_instr_mem[r_wr_ptr] <= fetch_instr;
      end
   end

`ifdef IF_ID_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (id_valid && id_stall && !flush && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (flush && (r_flush_count != 32'hFFFF_FFFF))
            r_flush_count <= r_flush_count + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`endif

endmodule
